// File: rtl/robot_pkg.sv
// Shared robot constants and the ranging FSM state type.
// Timing defaults assume a 50 MHz core clock and are also used by the PWM and encoder blocks.
// No ports: types, constants and a small helper only.
package robot_pkg;

    // 50 MHz-derived ultrasonic ranging defaults
    localparam int SCAN_NUM_SENSORS   = 4;
    localparam int SCAN_SETTLE_CYCLES = 50;
    localparam int SCAN_TRIG_CYCLES   = 500;        // 10 us
    localparam int SCAN_ECHO_WAIT     = 1_500_000;  // 30 ms
    localparam int SCAN_TICKS_PER_CM  = 2900;       // 58 us per cm
    localparam int SCAN_TIMEOUT_CM    = 400;
    localparam int SCAN_GAP_CYCLES    = 3_000_000;  // 60 ms
    localparam int SCAN_DIST_W        = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_REPORT,
        ST_GAP
    } scanner_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/echo_sync_edge.sv
// Two-flop synchronizer for the asynchronous echo pin plus rise/fall pulse detection.
// Latency: 2 cycles from pin edge to echo_s_o/rise_s_o/fall_s_o; pulse width preserved.
// No backpressure; ports: clk, reset (sync, active-high), echo_i in; echo_s_o, rise_s_o, fall_s_o out.
module echo_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic echo_i,
    output logic echo_s_o,
    output logic rise_s_o,
    output logic fall_s_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= echo_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign echo_s_o = sync_q;
    assign rise_s_o = sync_q & ~prev_q;
    assign fall_s_o = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_scanner.sv
// Round-robin ultrasonic ranging front end: mux select, trigger, echo width to cm, one result per sensor.
// Latency: result valid 1 cycle after echo fall is seen (echo seen 2 cycles after the pin edge).
// Backpressure: result held in REPORT until dist_valid & dist_ready; scanning stalls meanwhile.
// Ports: clk, reset (sync, active-high), enable, echo_rx in; trig_tx, mux_sensor_select out;
//        dist_valid/dist_ready handshake carrying dist_sensor, dist_cm, dist_timeout.
module ultrasonic_scanner
    import robot_pkg::*;
#(
    parameter int NUM_SENSORS   = SCAN_NUM_SENSORS,
    parameter int SETTLE_CYCLES = SCAN_SETTLE_CYCLES,
    parameter int TRIG_CYCLES   = SCAN_TRIG_CYCLES,
    parameter int ECHO_WAIT     = SCAN_ECHO_WAIT,
    parameter int TICKS_PER_CM  = SCAN_TICKS_PER_CM,
    parameter int TIMEOUT_CM    = SCAN_TIMEOUT_CM,
    parameter int GAP_CYCLES    = SCAN_GAP_CYCLES,
    parameter int DIST_W        = SCAN_DIST_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              echo_rx,
    output logic              trig_tx,
    output logic [3:0]        mux_sensor_select,
    output logic              dist_valid,
    input  logic              dist_ready,
    output logic [3:0]        dist_sensor,
    output logic [DIST_W-1:0] dist_cm,
    output logic              dist_timeout
);

    localparam int PH_MAX = max_int(max_int(SETTLE_CYCLES, TRIG_CYCLES), max_int(ECHO_WAIT, GAP_CYCLES));
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int PS_W   = max_int(1, $clog2(TICKS_PER_CM));

    localparam logic [PH_W-1:0]   SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0]   TRIG_LAST   = PH_W'(TRIG_CYCLES - 1);
    localparam logic [PH_W-1:0]   WAIT_LAST   = PH_W'(ECHO_WAIT - 1);
    localparam logic [PH_W-1:0]   GAP_LAST    = PH_W'(GAP_CYCLES - 1);
    localparam logic [PS_W-1:0]   PS_LAST     = PS_W'(TICKS_PER_CM - 1);
    localparam logic [DIST_W-1:0] CM_MAX      = DIST_W'(TIMEOUT_CM);
    localparam logic [3:0]        IDX_LAST    = 4'(NUM_SENSORS - 1);

    scanner_state_t    state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [PS_W-1:0]   presc_q, presc_d;
    logic [DIST_W-1:0] cm_q, cm_d;
    logic [3:0]        idx_q, idx_d;
    logic              trig_q;
    logic              valid_q;
    logic [3:0]        res_sensor_q;
    logic [DIST_W-1:0] res_cm_q;
    logic              res_to_q;

    logic              echo_s, rise_s, fall_s;
    logic              load_res;
    logic [DIST_W-1:0] res_cm;
    logic              res_to;
    logic [PS_W-1:0]   cnt_presc, inc_presc;
    logic [DIST_W-1:0] cnt_cm, inc_cm;

    echo_sync_edge u_echo_sync (
        .clk      (clk),
        .reset    (reset),
        .echo_i   (echo_rx),
        .echo_s_o (echo_s),
        .rise_s_o (rise_s),
        .fall_s_o (fall_s)
    );

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        presc_d  = presc_q;
        cm_d     = cm_q;
        idx_d    = idx_q;
        load_res = 1'b0;
        res_cm   = cm_q;
        res_to   = 1'b0;

        // One echo-high cycle counted; the rise cycle starts from a cleared count.
        cnt_presc = (state_q == ST_MEASURE) ? presc_q : '0;
        cnt_cm    = (state_q == ST_MEASURE) ? cm_q : '0;
        if (cnt_presc == PS_LAST) begin
            inc_presc = '0;
            inc_cm    = cnt_cm + 1'b1;
        end else begin
            inc_presc = cnt_presc + 1'b1;
            inc_cm    = cnt_cm;
        end

        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                if (enable) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (phase_q == SETTLE_LAST) begin
                    state_d = ST_TRIG;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_TRIG: begin
                if (phase_q == TRIG_LAST) begin
                    state_d = ST_WAIT_RISE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_WAIT_RISE, ST_MEASURE: begin
                if (state_q == ST_MEASURE && fall_s) begin
                    state_d  = ST_REPORT;
                    load_res = 1'b1;
                    res_cm   = cm_q;
                end else if (state_q == ST_MEASURE || rise_s) begin
                    presc_d = inc_presc;
                    cm_d    = inc_cm;
                    if (inc_cm == CM_MAX) begin
                        state_d  = ST_REPORT;
                        load_res = 1'b1;
                        res_cm   = CM_MAX;
                        res_to   = 1'b1;
                    end else begin
                        state_d = ST_MEASURE;
                    end
                end else if (phase_q == WAIT_LAST) begin
                    state_d  = ST_REPORT;
                    load_res = 1'b1;
                    res_cm   = CM_MAX;
                    res_to   = 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_REPORT: begin
                if (valid_q && dist_ready) begin
                    idx_d   = (idx_q == IDX_LAST) ? 4'd0 : idx_q + 4'd1;
                    state_d = enable ? ST_GAP : ST_IDLE;
                    phase_d = '0;
                end
            end
            ST_GAP: begin
                // Holdoff also waits out an echo that is still high (stuck sensor).
                if (phase_q != GAP_LAST) begin
                    phase_d = phase_q + 1'b1;
                end else if (!echo_s) begin
                    state_d = ST_SETTLE;
                    phase_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Dropping enable abandons the cycle; a result already in REPORT is still delivered.
        if (!enable && state_q inside {ST_SETTLE, ST_TRIG, ST_WAIT_RISE, ST_MEASURE, ST_GAP}) begin
            state_d  = ST_IDLE;
            phase_d  = '0;
            load_res = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            presc_q      <= '0;
            cm_q         <= '0;
            idx_q        <= '0;
            trig_q       <= 1'b0;
            valid_q      <= 1'b0;
            res_sensor_q <= '0;
            res_cm_q     <= '0;
            res_to_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            presc_q <= presc_d;
            cm_q    <= cm_d;
            idx_q   <= idx_d;
            // Registered from next state so the pin is glitch-free and high exactly in TRIG.
            trig_q  <= (state_d == ST_TRIG);
            if (load_res) begin
                valid_q      <= 1'b1;
                res_sensor_q <= idx_q;
                res_cm_q     <= res_cm;
                res_to_q     <= res_to;
            end else if (valid_q && dist_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign trig_tx           = trig_q;
    assign mux_sensor_select = idx_q;
    assign dist_valid        = valid_q;
    assign dist_sensor       = res_sensor_q;
    assign dist_cm           = res_cm_q;
    assign dist_timeout      = res_to_q;

endmodule
